// File: rtl/mem_cmd_responder.sv
// Memory endpoint for the accelerator command bus: decodes read/write commands,
// moves bytes between a byte-wide memory port and the accelerator streams, then acks.
module mem_cmd_responder #(
  parameter int         ADDRW      = 24,
  parameter logic [1:0] MY_ID      = 2'b00,
  parameter int         KEY_BYTES  = 32,
  parameter int         TEXT_BYTES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [ADDRW+7:0] cmd_data,
  output logic             busy,
  output logic             drop_err,
  output logic             mem_req,
  output logic             mem_we,
  output logic [ADDRW-1:0] mem_addr,
  output logic [7:0]       mem_wdata,
  input  logic             mem_ready,
  input  logic             mem_rvalid,
  input  logic [7:0]       mem_rdata,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  output logic [1:0]       tx_dest,
  input  logic             tx_ready,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             rx_ready,
  output logic [2:0]       ack_out,
  output logic [2:0]       fsm_state
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RD_ISSUE = 3'd1;
  localparam logic [2:0] S_RD_WAIT  = 3'd2;
  localparam logic [2:0] S_RD_SEND  = 3'd3;
  localparam logic [2:0] S_WR_RECV  = 3'd4;
  localparam logic [2:0] S_WR_ISSUE = 3'd5;
  localparam logic [2:0] S_ACK      = 3'd6;

  localparam logic [5:0] KEY_LAST  = 6'(KEY_BYTES - 1);
  localparam logic [5:0] TEXT_LAST = 6'(TEXT_BYTES - 1);

  logic [2:0]       state;
  logic [ADDRW-1:0] base;
  logic [5:0]       cnt;
  logic [5:0]       last;
  logic [7:0]       wdata;

  logic [1:0] opcode;
  logic [1:0] src_id;
  logic [1:0] dst_id;
  logic       is_rd;
  logic       is_wr;
  logic       hit;
  logic       unused_flags;

  assign opcode       = cmd_data[1:0];
  assign src_id       = cmd_data[3:2];
  assign dst_id       = cmd_data[5:4];
  assign unused_flags = ^cmd_data[7:6];

  assign is_rd = cmd_valid && (opcode == 2'b00 || opcode == 2'b01) && (src_id == MY_ID);
  assign is_wr = cmd_valid && (opcode == 2'b10) && (dst_id == MY_ID);
  assign hit   = is_rd || is_wr;

  // Handshakes: a transfer on mem/tx/rx happens on the rising edge where both
  // the request side (mem_req/tx_valid/rx_valid) and the accept side
  // (mem_ready/tx_ready/rx_ready) are high; requests are held with stable
  // payload until then.
  assign busy      = (state != S_IDLE);
  assign mem_req   = (state == S_RD_ISSUE) || (state == S_WR_ISSUE);
  assign mem_we    = (state == S_WR_ISSUE);
  assign mem_addr  = base + ADDRW'(cnt);
  assign mem_wdata = wdata;
  assign tx_valid  = (state == S_RD_SEND);
  assign rx_ready  = (state == S_WR_RECV);
  assign ack_out   = (state == S_ACK) ? {1'b1, MY_ID} : 3'b000;
  assign fsm_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      base     <= '0;
      cnt      <= '0;
      last     <= '0;
      wdata    <= '0;
      tx_data  <= '0;
      tx_dest  <= '0;
      drop_err <= 1'b0;
    end else begin
      // A matching command that arrives mid-transfer is flagged and discarded.
      drop_err <= hit && (state != S_IDLE);
      case (state)
        S_IDLE: begin
          if (hit) begin
            base    <= cmd_data[ADDRW+7:8];
            tx_dest <= dst_id;
            cnt     <= '0;
            last    <= (opcode == 2'b00) ? KEY_LAST : TEXT_LAST;
            state   <= is_rd ? S_RD_ISSUE : S_WR_RECV;
          end
        end
        S_RD_ISSUE: begin
          if (mem_ready) state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (mem_rvalid) begin
            tx_data <= mem_rdata;
            state   <= S_RD_SEND;
          end
        end
        S_RD_SEND: begin
          if (tx_ready) begin
            if (cnt == last) begin
              state <= S_ACK;
            end else begin
              cnt   <= cnt + 6'd1;
              state <= S_RD_ISSUE;
            end
          end
        end
        S_WR_RECV: begin
          if (rx_valid) begin
            wdata <= rx_data;
            state <= S_WR_ISSUE;
          end
        end
        S_WR_ISSUE: begin
          if (mem_ready) begin
            if (cnt == last) begin
              state <= S_ACK;
            end else begin
              cnt   <= cnt + 6'd1;
              state <= S_WR_RECV;
            end
          end
        end
        S_ACK:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_cmd_responder.sv
// Directed bench for mem_cmd_responder: a table of command scenarios plus
// hand-written filter and mid-transfer reset sequences.
module tb_mem_cmd_responder;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic [31:0] cmd_data;
  logic        busy;
  logic        drop_err;
  logic        mem_req;
  logic        mem_we;
  logic [23:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ready;
  logic        mem_rvalid;
  logic [7:0]  mem_rdata;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic [1:0]  tx_dest;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic [2:0]  ack_out;
  logic [2:0]  fsm_state;

  mem_cmd_responder #(
    .ADDRW(24), .MY_ID(2'b00), .KEY_BYTES(32), .TEXT_BYTES(16)
  ) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .busy(busy), .drop_err(drop_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_dest(tx_dest), .tx_ready(tx_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .ack_out(ack_out), .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] cmd;
    bit          is_write;
    int          nbytes;
    logic [23:0] addr0;
    logic [1:0]  dest;
    bit          stall;
    int          cycles;
    logic [7:0]  rx_base;
    int          collide_at;
    int          exp_drop;
  } vec_t;

  vec_t vecs[6];

  int checks = 0;
  int errors = 0;

  // environment model state
  bit          stall;
  bit          cmd_pend;
  logic [31:0] cmd_next;
  bit          rd_pending;
  logic [23:0] rd_addr;
  logic [7:0]  rx_base;
  int          rx_idx;
  logic [1:0]  cur_dest;
  bit          pv_mem_stall, pv_tx_stall, pv_rx_stall;
  logic [23:0] pv_addr;
  logic        pv_we;
  logic [7:0]  pv_wdata, pv_txd;
  logic [1:0]  pv_dest;

  // scoreboard
  logic [23:0] addr_q[$];
  logic [7:0]  data_q[$];
  logic [31:0] exp_q[$];
  int rd_cnt, wr_cnt, ack_cnt, drop_cnt, busy_cyc;

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_logs();
    addr_q.delete();
    data_q.delete();
    exp_q.delete();
    rd_cnt = 0; wr_cnt = 0; ack_cnt = 0; drop_cnt = 0; busy_cyc = 0;
  endtask

  // driver: one clock of the memory / stream / command environment
  task automatic step();
    @(negedge clk);
    cmd_valid = cmd_pend;
    cmd_data  = cmd_next;
    cmd_pend  = 1'b0;
    if (rst) begin
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 8'h00;
      tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      rd_pending = 1'b0;
      pv_mem_stall = 1'b0; pv_tx_stall = 1'b0; pv_rx_stall = 1'b0;
      return;
    end
    if (pv_mem_stall)
      chk("mem_hold", 40'({mem_req, mem_we, mem_addr, mem_we ? mem_wdata : 8'h00}),
                      40'({1'b1, pv_we, pv_addr, pv_we ? pv_wdata : 8'h00}));
    if (pv_tx_stall)
      chk("tx_hold", 40'({tx_valid, tx_data, tx_dest}), 40'({1'b1, pv_txd, pv_dest}));
    if (pv_rx_stall)
      chk("rx_hold", 40'(rx_ready), 40'(1'b1));

    if (rd_pending && (!stall || $urandom_range(0, 2) != 0)) begin
      mem_rvalid = 1'b1;
      mem_rdata  = rd_addr[7:0];
      rd_pending = 1'b0;
    end else if (!rd_pending && stall && $urandom_range(0, 3) == 0) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 8'hEE;
    end else begin
      mem_rvalid = 1'b0;
      mem_rdata  = 8'h00;
    end

    mem_ready    = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
    pv_mem_stall = mem_req && !mem_ready;
    pv_addr = mem_addr; pv_we = mem_we; pv_wdata = mem_wdata;
    if (mem_req && mem_ready) begin
      addr_q.push_back(mem_addr);
      if (mem_we) begin
        wr_cnt++;
        data_q.push_back(mem_wdata);
      end else begin
        rd_cnt++;
        rd_pending = 1'b1;
        rd_addr    = mem_addr;
      end
    end

    tx_ready    = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
    pv_tx_stall = tx_valid && !tx_ready;
    pv_txd = tx_data; pv_dest = tx_dest;
    if (tx_valid && tx_ready) begin
      data_q.push_back(tx_data);
      chk("tx_dest", 40'(tx_dest), 40'(cur_dest));
    end

    rx_valid    = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
    rx_data     = rx_base + 8'(rx_idx);
    pv_rx_stall = rx_ready && !rx_valid;
    if (rx_ready && rx_valid) rx_idx++;

    if (ack_out != 3'b000) begin
      ack_cnt++;
      chk("ack_value", 40'(ack_out), 40'(3'b100));
    end
    if (drop_err) drop_cnt++;
    if (busy && ack_out == 3'b000) busy_cyc++;
  endtask

  task automatic run_vec(input vec_t v);
    bit done;
    logic [23:0] a;
    logic [7:0]  d;
    logic [31:0] e;
    clear_logs();
    stall = v.stall; rx_base = v.rx_base; rx_idx = 0; cur_dest = v.dest;
    cmd_next = v.cmd; cmd_pend = 1'b1;
    step();
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      if (i == v.collide_at) begin
        cmd_next = {24'h000900, 8'b00_10_00_00}; cmd_pend = 1'b1;
      end
      if (v.collide_at >= 0 && i == v.collide_at + 4) begin
        cmd_next = {24'h000900, 8'b00_00_01_01}; cmd_pend = 1'b1;
      end
      step();
      if (ack_cnt != 0) done = 1'b1;
    end
    chk("ack_seen", 40'(done), 40'(1'b1));
    repeat (3) step();
    chk("ack_count", 40'(ack_cnt), 40'(1));
    chk("idle_after", 40'(busy), 40'(1'b0));
    chk("drop_count", 40'(drop_cnt), 40'(v.exp_drop));
    if (v.cycles >= 0) chk("cycles", 40'(busy_cyc), 40'(v.cycles));
    chk("rd_reqs", 40'(rd_cnt), 40'(v.is_write ? 0 : v.nbytes));
    chk("wr_reqs", 40'(wr_cnt), 40'(v.is_write ? v.nbytes : 0));
    chk("byte_count", 40'(data_q.size()), 40'(v.nbytes));
    for (int i = 0; i < v.nbytes; i++) begin
      a = v.addr0 + 24'(i);
      d = v.is_write ? (v.rx_base + 8'(i)) : a[7:0];
      exp_q.push_back({a, d});
    end
    for (int i = 0; i < v.nbytes; i++) begin
      e = exp_q.pop_front();
      if (i < addr_q.size() && i < data_q.size())
        chk("xfer_byte", 40'({addr_q[i], data_q[i]}), 40'(e));
    end
  endtask

  initial begin
    bit reached;
    vecs[0] = '{{24'h000100, 8'b00_10_00_00}, 1'b0, 32, 24'h000100, 2'b10, 1'b0, 96, 8'h00, -1, 0};
    vecs[1] = '{{24'h000200, 8'b00_00_10_10}, 1'b1, 16, 24'h000200, 2'b00, 1'b0, 32, 8'hA0, -1, 0};
    vecs[2] = '{{24'h000340, 8'b00_01_00_01}, 1'b0, 16, 24'h000340, 2'b01, 1'b1, -1, 8'h00, -1, 0};
    vecs[3] = '{{24'hFFFFF8, 8'b00_11_00_01}, 1'b0, 16, 24'hFFFFF8, 2'b11, 1'b0, 48, 8'h00, -1, 0};
    vecs[4] = '{{24'h000050, 8'b11_00_01_10}, 1'b1, 16, 24'h000050, 2'b00, 1'b1, -1, 8'h30, -1, 0};
    vecs[5] = '{{24'h000400, 8'b00_01_00_01}, 1'b0, 16, 24'h000400, 2'b01, 1'b0, 48, 8'h00, 10, 1};

    rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; cmd_pend = 1'b0; cmd_next = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    stall = 1'b0; rx_base = '0; rx_idx = 0; cur_dest = '0; rd_pending = 1'b0; rd_addr = '0;
    pv_mem_stall = 1'b0; pv_tx_stall = 1'b0; pv_rx_stall = 1'b0;
    pv_addr = '0; pv_we = 1'b0; pv_wdata = '0; pv_txd = '0; pv_dest = '0;
    clear_logs();

    repeat (3) step();
    chk("reset_ctrl", 40'({busy, drop_err, mem_req, mem_we, tx_valid, rx_ready, ack_out, fsm_state}), 40'(0));
    chk("reset_data", 40'({mem_addr, mem_wdata}), 40'(0));
    chk("reset_tx", 40'({tx_data, tx_dest}), 40'(0));
    @(posedge clk); #1 rst = 1'b0;

    for (int k = 0; k < 6; k++) run_vec(vecs[k]);

    // ignored words: opcode 11, read from another source, write to another dest
    clear_logs();
    stall = 1'b0;
    cmd_next = {24'h000500, 8'b00_00_00_11}; cmd_pend = 1'b1; step(); repeat (3) step();
    chk("ignore_op11", 40'(busy), 40'(1'b0));
    cmd_next = {24'h000500, 8'b00_00_01_00}; cmd_pend = 1'b1; step(); repeat (3) step();
    chk("ignore_src", 40'(busy), 40'(1'b0));
    cmd_next = {24'h000500, 8'b00_01_00_10}; cmd_pend = 1'b1; step(); repeat (3) step();
    chk("ignore_dest", 40'(busy), 40'(1'b0));
    chk("ignore_activity", 40'(rd_cnt + wr_cnt + ack_cnt + drop_cnt), 40'(0));

    // reset in the middle of a write
    clear_logs();
    stall = 1'b0; rx_base = 8'h10; rx_idx = 0; cur_dest = 2'b00;
    cmd_next = {24'h000600, 8'b00_00_11_10}; cmd_pend = 1'b1;
    step();
    reached = 1'b0;
    for (int i = 0; i < 100 && !reached; i++) begin
      step();
      if (rx_idx >= 5) reached = 1'b1;
    end
    chk("rst_reach_byte5", 40'(reached), 40'(1'b1));
    @(posedge clk); #1 rst = 1'b1;
    #1;
    chk("midrst_ctrl", 40'({busy, drop_err, mem_req, mem_we, tx_valid, rx_ready, ack_out, fsm_state}), 40'(0));
    chk("midrst_data", 40'({mem_addr, mem_wdata, tx_data, tx_dest}), 40'(0));
    repeat (3) step();
    chk("midrst_no_ack", 40'(ack_cnt), 40'(0));
    @(posedge clk); #1 rst = 1'b0;
    run_vec(vecs[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
